// File: rtl/alu_seq.sv
// alu_seq: command sequencer around an external combinational ALU.
// Accepts LOAD / ALU / CLR / READ commands, keeps the accumulator (ACC),
// presents operands to the ALU, and returns each result through a
// valid/ready response port. It also counts completed responses.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    // command port
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_kind,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_imm,
    // external ALU
    output logic [W-1:0] alu_A,
    output logic [W-1:0] alu_B,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_S,
    // response port
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_zero,
    output logic         res_neg,
    output logic [7:0]   op_count
);

    localparam logic [1:0] KIND_LOAD = 2'b00;
    localparam logic [1:0] KIND_ALU  = 2'b01;
    localparam logic [1:0] KIND_CLR  = 2'b10;
    localparam logic [1:0] KIND_READ = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] acc;
    logic [W-1:0] op_b;
    logic [2:0]   op_c;
    logic         cmd_acc;
    logic         res_done;

    // Handshake qualifiers; commands are only taken in IDLE.
    assign cmd_ready = (state == IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign res_valid = (state == RESP);
    assign res_done  = res_valid && res_ready;

    // Outputs are direct views of the registered state, so the response
    // stays stable for as long as the consumer stalls.
    assign alu_A    = acc;
    assign alu_B    = op_b;
    assign alu_op   = op_c;
    assign res_data = acc;
    assign res_zero = (acc == '0);
    assign res_neg  = acc[W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: ALU commands take one extra EXEC cycle, the rest
    // go straight to RESP; RESP waits for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd_kind == KIND_ALU) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and registered ALU operands; fields of the command are
    // sampled only on the accept edge. Reset discards any pending command.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            op_b <= '0;
            op_c <= 3'b000;
        end else if (cmd_acc) begin
            case (cmd_kind)
                KIND_LOAD: acc <= cmd_imm;
                KIND_ALU: begin
                    op_b <= cmd_imm;
                    op_c <= cmd_op;
                end
                KIND_CLR:  acc <= '0;
                KIND_READ: acc <= acc;
                default:   acc <= acc;
            endcase
        end else if (state == EXEC) begin
            acc <= alu_S;
        end
    end

    // Completed-response counter, wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= 8'd0;
        end else if (res_done) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule
